// File: rtl/bcd_cascade_pkg.sv
// rtl/bcd_cascade_pkg.sv - shared widths, segment lookup and prescaler width helper
package bcd_cascade_pkg;

    localparam int SEG_WIDTH   = 8;
    localparam int DIGIT_WIDTH = 4;

    // Hex digit to segment pattern, bit order {dp,g,f,e,d,c,b,a}, active-high, dp off.
    localparam logic [SEG_WIDTH-1:0] SEG_LUT [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // Prescaler register width; a divide of 1 still keeps a 1-bit register.
    function automatic int prescale_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/bcd_cascade_counter_display_digit_cell.sv
// rtl/bcd_cascade_counter_display_digit_cell.sv - one radix-BASE counter digit
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (value -> 0)
//   step_in       advance this digit by one in the up_down direction
//   up_down       1 = up, 0 = down
//   load          parallel load strobe, takes priority over step_in
//   load_val      value to load, clamped to BASE-1
//   value         registered digit value
//   at_limit      digit sits at BASE-1 (up) or 0 (down), i.e. the next step rolls over
module digit_cell
    import bcd_cascade_pkg::*;
#(
    parameter int BASE = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_in,
    input  logic                   up_down,
    input  logic                   load,
    input  logic [DIGIT_WIDTH-1:0] load_val,
    output logic [DIGIT_WIDTH-1:0] value,
    output logic                   at_limit
);

    localparam logic [DIGIT_WIDTH-1:0] MAX_VAL = DIGIT_WIDTH'(BASE - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step_in) begin
            if (up_down) begin
                value <= (value == MAX_VAL) ? '0 : value + 1'b1;
            end else begin
                value <= (value == '0) ? MAX_VAL : value - 1'b1;
            end
        end
    end

    assign at_limit = up_down ? (value == MAX_VAL) : (value == '0);

endmodule

// File: rtl/bcd_cascade_counter_display.sv
// rtl/bcd_cascade_counter_display.sv - cascaded radix-BASE up/down counter with 7-segment outputs
//
// Optional feature macro: BCD_CASCADE_BLANK_LEADING_ZERO_EN (blank leading zero digits).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   en         count enable; low freezes prescaler and digits
//   up_down    1 = count up, 0 = count down (sampled on tick)
//   load       synchronous parallel load strobe
//   load_data  DIGITS x 4-bit digits, digit 0 in [3:0]
//   count      registered digit values, same packing as load_data
//   wrap       one-cycle pulse after a full-range wrap
//   out_leds   DIGITS x 8-bit segment patterns, digit 0 in [7:0]
module bcd_cascade_counter_display
    import bcd_cascade_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int BASE     = 10,
    parameter int TICK_DIV = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          up_down,
    input  logic                          load,
    input  logic [DIGITS*DIGIT_WIDTH-1:0] load_data,
    output logic [DIGITS*DIGIT_WIDTH-1:0] count,
    output logic                          wrap,
    output logic [DIGITS*SEG_WIDTH-1:0]   out_leds
);

    localparam int PRESC_W = prescale_width(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [DIGITS-1:0]  at_limit;
    logic [DIGITS-1:0]  step;

    // With TICK_DIV=1 presc stays 0 == PRESC_LAST, so tick degenerates to en.
    assign tick = en && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Carry/borrow chain is purely combinational so every digit moves on the same edge.
    assign step[0] = tick;
    for (genvar i = 1; i < DIGITS; i++) begin : g_chain
        assign step[i] = step[i-1] & at_limit[i-1];
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        digit_cell #(
            .BASE(BASE)
        ) u_digit (
            .clk      (clk),
            .rst      (rst),
            .step_in  (step[i]),
            .up_down  (up_down),
            .load     (load),
            .load_val (load_data[i*DIGIT_WIDTH +: DIGIT_WIDTH]),
            .value    (count[i*DIGIT_WIDTH +: DIGIT_WIDTH]),
            .at_limit (at_limit[i])
        );
    end

    // A step that reaches past the top digit is a full-range wrap.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= step[DIGITS-1] & at_limit[DIGITS-1];
        end
    end

    always_comb begin
        logic [DIGIT_WIDTH-1:0] d;
        logic                   seen_nonzero;
        out_leds     = '0;
        d            = '0;
        seen_nonzero = 1'b0;
        // Walk from the most significant digit so leading zeros can be detected.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = count[i*DIGIT_WIDTH +: DIGIT_WIDTH];
            if (d != '0) begin
                seen_nonzero = 1'b1;
            end
`ifdef BCD_CASCADE_BLANK_LEADING_ZERO_EN
            if (seen_nonzero || (i == 0)) begin
                out_leds[i*SEG_WIDTH +: SEG_WIDTH] = SEG_LUT[d];
            end
`else
            out_leds[i*SEG_WIDTH +: SEG_WIDTH] = SEG_LUT[d];
`endif
        end
    end

endmodule

// File: tb/tb_bcd_cascade_counter_display.sv
// tb/tb_bcd_cascade_counter_display.sv - directed self-checking bench for bcd_cascade_counter_display
module tb_bcd_cascade_counter_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        up_down;
    logic        load;
    logic [23:0] load_data;

    logic [23:0] count1, count4;
    logic        wrap1, wrap4;
    logic [47:0] leds1, leds4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_cascade_counter_display #(.DIGITS(6), .BASE(10), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_data(load_data), .count(count1), .wrap(wrap1), .out_leds(leds1)
    );

    bcd_cascade_counter_display #(.DIGITS(6), .BASE(10), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
        .load_data(load_data), .count(count4), .wrap(wrap4), .out_leds(leds4)
    );

    task automatic step_clk(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0; load_data = '0;
        step_clk(2);
        check("reset_count1", count1, 24'h000000);
        check("reset_wrap1", wrap1, 1'b0);
        check("reset_leds1", leds1, 48'h3F3F3F3F3F3F);
        check("reset_count4", count4, 24'h000000);

        // Up carry in a single edge
        rst = 1'b0; load = 1'b1; load_data = 24'h000099;
        step_clk(1);
        check("load_099", count1, 24'h000099);
`ifdef BCD_CASCADE_BLANK_LEADING_ZERO_EN
        check("leds_099", leds1, 48'h000000006F6F);
`else
        check("leds_099", leds1, 48'h3F3F3F3F6F6F);
`endif
        load = 1'b0; en = 1'b1; up_down = 1'b1;
        step_clk(1);
        check("up_carry", count1, 24'h000100);
        check("up_carry_wrap", wrap1, 1'b0);

        // Up wrap, pulse lasts exactly one cycle
        en = 1'b0; load = 1'b1; load_data = 24'h999999;
        step_clk(1);
        check("leds_999999", leds1, 48'h6F6F6F6F6F6F);
        load = 1'b0; en = 1'b1;
        step_clk(1);
        check("up_wrap_count", count1, 24'h000000);
        check("up_wrap_pulse", wrap1, 1'b1);
        step_clk(1);
        check("up_after_wrap_count", count1, 24'h000001);
        check("up_after_wrap_pulse", wrap1, 1'b0);

        // Down borrow and underflow wrap
        en = 1'b0; load = 1'b1; load_data = 24'h000100;
        step_clk(1);
        load = 1'b0; up_down = 1'b0; en = 1'b1;
        step_clk(1);
        check("down_borrow", count1, 24'h000099);
        en = 1'b0; load = 1'b1; load_data = 24'h000000;
        step_clk(1);
        load = 1'b0; en = 1'b1;
        step_clk(1);
        check("down_wrap_count", count1, 24'h999999);
        check("down_wrap_pulse", wrap1, 1'b1);
        en = 1'b0;
        step_clk(1);
        check("down_hold_count", count1, 24'h999999);
        check("down_wrap_clear", wrap1, 1'b0);

        // Prescaler, TICK_DIV=4
        up_down = 1'b1; load = 1'b1; load_data = 24'h000000;
        step_clk(1);
        load = 1'b0; en = 1'b1;
        step_clk(3);
        check("presc_3_edges", count4, 24'h000000);
        step_clk(1);
        check("presc_4th_edge", count4, 24'h000001);
        step_clk(2);
        en = 1'b0;
        step_clk(3);
        check("presc_hold", count4, 24'h000001);
        en = 1'b1;
        step_clk(1);
        check("presc_resume_1", count4, 24'h000001);
        step_clk(1);
        check("presc_resume_2", count4, 24'h000002);

        // Load beats a simultaneous tick, digit clamped, prescaler cleared
        step_clk(3);
        check("presc_pre_load", count4, 24'h000002);
        load = 1'b1; load_data = 24'h00000C;
        step_clk(1);
        check("load_clamp4", count4, 24'h000009);
        check("load_clamp1", count1, 24'h000009);
        load = 1'b0;
        step_clk(3);
        check("load_presc_cleared", count4, 24'h000009);
        step_clk(1);
        check("load_presc_tick", count4, 24'h000010);

        en = 1'b0; load = 1'b1; load_data = 24'hFA0B3C;
        step_clk(1);
        check("clamp_multi", count1, 24'h990939);

        // Reset overrides load
        rst = 1'b1; load = 1'b1; load_data = 24'h123456;
        step_clk(1);
        check("rst_over_load1", count1, 24'h000000);
        check("rst_over_load4", count4, 24'h000000);
        rst = 1'b0;

        // Display / blanking
        load_data = 24'h000042;
        step_clk(1);
`ifdef BCD_CASCADE_BLANK_LEADING_ZERO_EN
        check("leds_42", leds1, 48'h00000000665B);
`else
        check("leds_42", leds1, 48'h3F3F3F3F665B);
`endif
        load_data = 24'h000000;
        step_clk(1);
`ifdef BCD_CASCADE_BLANK_LEADING_ZERO_EN
        check("leds_zero", leds1, 48'h00000000003F);
`else
        check("leds_zero", leds1, 48'h3F3F3F3F3F3F);
`endif
        load_data = 24'h0A0bCd;
        load_data = 24'h000D0F;
        step_clk(1);
        check("load_hex_clamped", count1, 24'h000909);
        load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
